// File: rtl/bcd_scan_ctrl_if.sv
// Bus bundle between a display host and bcd_scan_ctrl: load handshake,
// error clear, and the digit-scan outputs that drive the shared decoder.
interface bcd_scan_ctrl_if #(
    parameter int NDIG = 4
);
    logic              en;
    logic [4*NDIG-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic              err_clr;
    logic [3:0]        bcd_out;
    logic [NDIG-1:0]   dig_sel;
    logic              blank;
    logic              err;
    logic              frame_done;

    modport master (
        output en, data_in, data_valid, err_clr,
        input  data_ready, bcd_out, dig_sel, blank, err, frame_done
    );

    modport slave (
        input  en, data_in, data_valid, err_clr,
        output data_ready, bcd_out, dig_sel, blank, err, frame_done
    );
endinterface

// File: rtl/bcd_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit BCD display.
// Each digit is shown for PRESC cycles followed by GUARD dark cycles.
// Leading zeros can be blanked, and codes above 9 are blanked and flagged.
// Outputs are registered from the next-state values, so dig_sel/bcd_out
// line up with the state register on every edge.
module bcd_scan_ctrl #(
    parameter int NDIG  = 4,
    parameter int PRESC = 1000,
    parameter int GUARD = 10,
    parameter int LZB   = 1
) (
    input  logic           clk,
    input  logic           reset,
    bcd_scan_ctrl_if.slave bus
);
    localparam int TMAX = (PRESC > GUARD) ? PRESC : GUARD;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int IW   = $clog2(NDIG);
    localparam int DW   = 4 * NDIG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHOW  = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic [TW-1:0]   r_timer;
    logic [DW-1:0]   r_act;
    logic [DW-1:0]   r_pend;
    logic            r_ready;
    logic [3:0]      r_bcd;
    logic [NDIG-1:0] r_dig_sel;
    logic            r_blank;
    logic            r_err;
    logic            r_fd;

    state_t          w_state_next;
    logic [IW-1:0]   w_idx_next;
    logic [TW-1:0]   w_timer_next;
    logic            w_fd_next;
    logic            w_adv;
    logic            w_xfer;
    logic [DW-1:0]   w_act_next;
    logic [3:0]      w_dig [NDIG];
    logic [NDIG-1:0] w_zero_from;
    logic [3:0]      w_cur_dig;
    logic            w_cur_inv;
    logic            w_cur_lz;
    logic            w_show;
    logic            w_err_set;
    logic [NDIG-1:0] w_onehot;

    // Scan sequencing: slot timer, digit index and the frame-end pulse.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_timer_next = r_timer;
        w_fd_next    = 1'b0;
        w_adv        = 1'b0;
        if (!bus.en) begin
            w_state_next = S_IDLE;
            w_idx_next   = '0;
            w_timer_next = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_next = S_SHOW;
                    w_idx_next   = '0;
                    w_timer_next = '0;
                end
                S_SHOW: begin
                    if (r_timer == TW'(PRESC - 1)) begin
                        w_timer_next = '0;
                        if (GUARD > 0) begin
                            w_state_next = S_GUARD;
                        end else begin
                            w_adv = 1'b1;
                        end
                    end else begin
                        w_timer_next = r_timer + TW'(1);
                    end
                end
                S_GUARD: begin
                    if (r_timer == TW'(GUARD - 1)) begin
                        w_timer_next = '0;
                        w_adv        = 1'b1;
                    end else begin
                        w_timer_next = r_timer + TW'(1);
                    end
                end
                default: begin
                    w_state_next = S_IDLE;
                    w_idx_next   = '0;
                    w_timer_next = '0;
                end
            endcase
            if (w_adv) begin
                w_state_next = S_SHOW;
                w_fd_next    = (r_idx == IW'(NDIG - 1));
                w_idx_next   = w_fd_next ? '0 : r_idx + IW'(1);
            end
        end
    end

    // The pending word moves to the active buffer from IDLE or at a frame edge;
    // the new slot is decoded from the post-transfer buffer.
    assign w_xfer     = !r_ready && ((r_state == S_IDLE) || w_fd_next);
    assign w_act_next = w_xfer ? r_pend : r_act;

    // Per-digit nibble split and "this digit and everything above is zero".
    for (genvar gi = 0; gi < NDIG; gi++) begin : g_dig
        assign w_dig[gi]       = w_act_next[4*gi +: 4];
        assign w_zero_from[gi] = (w_act_next[DW-1:4*gi] == '0);
    end

    assign w_cur_dig = w_dig[w_idx_next];
    assign w_cur_inv = (w_cur_dig > 4'd9);
    assign w_cur_lz  = (LZB != 0) && (w_idx_next != '0) && w_zero_from[w_idx_next];
    assign w_show    = (w_state_next == S_SHOW);
    assign w_err_set = w_show && w_cur_inv;
    assign w_onehot  = NDIG'(1) << w_idx_next;

    // Single registered FSM: state, buffers, handshake and all outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_timer   <= '0;
            r_act     <= '0;
            r_pend    <= '0;
            r_ready   <= 1'b1;
            r_bcd     <= 4'd0;
            r_dig_sel <= '0;
            r_blank   <= 1'b1;
            r_err     <= 1'b0;
            r_fd      <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
            r_timer <= w_timer_next;
            r_fd    <= w_fd_next;
            r_act   <= w_act_next;
            if (bus.data_valid && r_ready) begin
                r_pend  <= bus.data_in;
                r_ready <= 1'b0;
            end else if (w_xfer) begin
                r_ready <= 1'b1;
            end
            r_err <= w_err_set || (r_err && !bus.err_clr);
            case (w_state_next)
                S_SHOW: begin
                    r_dig_sel <= w_onehot;
                    if (w_cur_inv || w_cur_lz) begin
                        r_bcd   <= 4'd0;
                        r_blank <= 1'b1;
                    end else begin
                        r_bcd   <= w_cur_dig;
                        r_blank <= 1'b0;
                    end
                end
                S_GUARD: begin
                    r_dig_sel <= '0;
                    r_blank   <= 1'b1;
                end
                default: begin
                    r_dig_sel <= '0;
                    r_blank   <= 1'b1;
                    r_bcd     <= 4'd0;
                end
            endcase
        end
    end

    assign bus.data_ready = r_ready;
    assign bus.bcd_out    = r_bcd;
    assign bus.dig_sel    = r_dig_sel;
    assign bus.blank      = r_blank;
    assign bus.err        = r_err;
    assign bus.frame_done = r_fd;
endmodule
